// File: rtl/useq_pkg.sv
// Shared encodings for the microsequencer next-address controller.
package useq_pkg;

    localparam int AW = 12;

    // Next-address select field of the microword; 5-7 decode as sequential.
    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_JUMP = 3'd1,
        SEL_CALL = 3'd2,
        SEL_RET  = 3'd3,
        SEL_DISP = 3'd4
    } sel_e;

    typedef enum logic [1:0] {
        FC_NONE = 2'b00,
        FC_OVF  = 2'b01,
        FC_UNF  = 2'b10
    } fault_code_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

endpackage

// File: rtl/useq_ret_stack.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; the controller's depth counter defines validity.
module useq_ret_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [AW-1:0]            rdata
);

    logic [AW-1:0] mem [DEPTH];

    // Write one return address per push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/useq_stack_ctl.sv
// Microsequencer next-address controller with call/return stack and
// overflow/underflow trapping into a FAULT state. DEPTH must be a power of 2, >= 2.
module useq_stack_ctl #(
    parameter int            AW         = useq_pkg::AW,
    parameter int            DEPTH      = 16,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clken,
    input  logic [2:0]             sel,
    input  logic [AW-1:0]          j,
    input  logic [AW-1:0]          disp,
    input  logic                   flush,
    input  logic                   fault_clr,
    output logic [AW-1:0]          addr,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   fault,
    output logic [1:0]             fault_code
);

    import useq_pkg::*;

    localparam int            IW   = $clog2(DEPTH);
    localparam int            DW   = IW + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    state_e        state_q, state_n;
    fault_code_e   fc_q, fc_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] depth_n;
    logic          push;
    logic [AW-1:0] seq_addr;
    logic [IW-1:0] top_idx;
    logic [AW-1:0] ret_addr;

    assign seq_addr = addr + 1'b1;
    // At depth==DEPTH the low bits wrap to 0, so top_idx still lands on the last entry.
    assign top_idx  = depth[IW-1:0] - 1'b1;

    // A RET right after a CALL needs no forwarding: the push is written at the
    // CALL edge and the read port is combinational during the following cycle.
    useq_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .we    (push & clken),
        .waddr (depth[IW-1:0]),
        .wdata (seq_addr),
        .raddr (top_idx),
        .rdata (ret_addr)
    );

    // Next-state, next-address and stack-pointer selection.
    always_comb begin
        state_n = state_q;
        fc_n    = fc_q;
        addr_n  = addr;
        depth_n = depth;
        push    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    addr_n  = RESET_ADDR;
                    depth_n = '0;
                end else begin
                    case (sel)
                        SEL_JUMP: addr_n = j;
                        SEL_DISP: addr_n = j | disp;
                        SEL_CALL: begin
                            if (depth != FULL) begin
                                push    = 1'b1;
                                depth_n = depth + 1'b1;
                                addr_n  = j;
                            end else begin
                                fc_n    = FC_OVF;
                                state_n = ST_FAULT;
                            end
                        end
                        SEL_RET: begin
                            if (depth != '0) begin
                                addr_n  = ret_addr;
                                depth_n = depth - 1'b1;
                            end else begin
                                fc_n    = FC_UNF;
                                state_n = ST_FAULT;
                            end
                        end
                        default: addr_n = seq_addr;
                    endcase
                end
            end
            ST_FAULT: begin
                if (flush) begin
                    state_n = ST_RUN;
                    fc_n    = FC_NONE;
                    addr_n  = RESET_ADDR;
                    depth_n = '0;
                end else if (fault_clr) begin
                    state_n = ST_RUN;
                    fc_n    = FC_NONE;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    // Register all controller state, advancing only on enabled microcycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fc_q    <= FC_NONE;
            addr    <= RESET_ADDR;
            depth   <= '0;
        end else if (clken) begin
            state_q <= state_n;
            fc_q    <= fc_n;
            addr    <= addr_n;
            depth   <= depth_n;
        end
    end

    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fc_q;

endmodule

// File: tb/tb_useq_stack_ctl.sv
// Self-checking bench for useq_stack_ctl: per-feature tasks feed a step table,
// push expected results to a scoreboard queue and compare after each edge.
module tb_useq_stack_ctl;

    localparam logic [2:0] S_SEQ  = 3'd0;
    localparam logic [2:0] S_JMP  = 3'd1;
    localparam logic [2:0] S_CALL = 3'd2;
    localparam logic [2:0] S_RET  = 3'd3;
    localparam logic [2:0] S_DISP = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clken;
    logic [2:0]  sel;
    logic [11:0] j;
    logic [11:0] disp;
    logic        flush;
    logic        fault_clr;
    logic [11:0] addr;
    logic [4:0]  depth;
    logic        fault;
    logic [1:0]  fault_code;

    typedef struct {
        logic [11:0] addr;
        logic [4:0]  depth;
        logic        fault;
        logic [1:0]  code;
    } exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] j;
        logic [11:0] disp;
        logic        flush;
        logic        fclr;
        logic        clken;
        exp_t        e;
    } step_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    useq_stack_ctl #(
        .AW         (12),
        .DEPTH      (16),
        .RESET_ADDR (12'o0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clken      (clken),
        .sel        (sel),
        .j          (j),
        .disp       (disp),
        .flush      (flush),
        .fault_clr  (fault_clr),
        .addr       (addr),
        .depth      (depth),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    function automatic exp_t mke(logic [11:0] a, logic [4:0] d, logic f, logic [1:0] c);
        exp_t e;
        e.addr = a; e.depth = d; e.fault = f; e.code = c;
        return e;
    endfunction

    function automatic step_t mk(logic [2:0] s, logic [11:0] jj, logic [11:0] dd,
                                 logic fl, logic fc, logic ce, exp_t e);
        step_t st;
        st.sel = s; st.j = jj; st.disp = dd; st.flush = fl; st.fclr = fc; st.clken = ce; st.e = e;
        return st;
    endfunction

    // Drive one microcycle's inputs and queue the result expected after the edge.
    task automatic apply(input step_t st);
        sel       = st.sel;
        j         = st.j;
        disp      = st.disp;
        flush     = st.flush;
        fault_clr = st.fclr;
        clken     = st.clken;
        exp_q.push_back(st.e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; clken = 1'b1; sel = S_SEQ; j = '0; disp = '0; flush = 1'b0; fault_clr = 1'b0;
        exp_q.push_back(mke(12'o0, 5'd0, 1'b0, 2'b00));
        #3;
        e = exp_q.pop_front();
        n_checks++;
        if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
            n_fail++;
            $display("FAIL reset: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                     addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
        end
        #4 rst_n = 1'b1;
    endtask

    task automatic test_seq();
        step_t s[$];
        exp_t  e;
        for (int i = 1; i <= 3; i++) s.push_back(mk(S_SEQ, 12'o0, 12'o0, 0, 0, 1, mke(12'(i), 5'd0, 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL seq[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    task automatic test_call_ret();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(S_JMP,  12'o0100, 12'o0, 0, 0, 1, mke(12'o0100, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o0200, 12'o0, 0, 0, 1, mke(12'o0200, 5'd1, 0, 2'b00)));
        s.push_back(mk(S_SEQ,  12'o0,    12'o0, 0, 0, 1, mke(12'o0201, 5'd1, 0, 2'b00)));
        s.push_back(mk(S_RET,  12'o0,    12'o0, 0, 0, 1, mke(12'o0101, 5'd0, 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL call_ret[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    task automatic test_overflow();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(S_SEQ, 12'o0, 12'o0, 1, 0, 1, mke(12'o0, 5'd0, 0, 2'b00)));
        for (int i = 0; i < 16; i++)
            s.push_back(mk(S_CALL, 12'o1000 + 12'(i), 12'o0, 0, 0, 1, mke(12'o1000 + 12'(i), 5'(i + 1), 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o7000, 12'o0, 0, 0, 1, mke(12'o1017, 5'd16, 1, 2'b01)));
        s.push_back(mk(S_SEQ,  12'o0,    12'o0, 0, 0, 1, mke(12'o1017, 5'd16, 1, 2'b01)));
        s.push_back(mk(S_CALL, 12'o7000, 12'o0, 0, 0, 1, mke(12'o1017, 5'd16, 1, 2'b01)));
        s.push_back(mk(S_CALL, 12'o7000, 12'o0, 0, 1, 1, mke(12'o1017, 5'd16, 0, 2'b00)));
        for (int k = 0; k < 16; k++)
            s.push_back(mk(S_RET, 12'o0, 12'o0, 0, 0, 1,
                           mke((15 - k >= 1) ? 12'o1000 + 12'(15 - k) : 12'o0001, 5'(15 - k), 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    task automatic test_underflow();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(S_RET, 12'o0,    12'o0, 0, 0, 1, mke(12'o0001, 5'd0, 1, 2'b10)));
        s.push_back(mk(S_SEQ, 12'o0,    12'o0, 0, 0, 1, mke(12'o0001, 5'd0, 1, 2'b10)));
        s.push_back(mk(S_JMP, 12'o0777, 12'o0, 0, 0, 1, mke(12'o0001, 5'd0, 1, 2'b10)));
        s.push_back(mk(S_JMP, 12'o0777, 12'o0, 1, 1, 1, mke(12'o0000, 5'd0, 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL underflow[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    task automatic test_wrap_jump_disp();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(S_JMP,  12'o7777, 12'o0,    0, 0, 1, mke(12'o7777, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_SEQ,  12'o0,    12'o0,    0, 0, 1, mke(12'o0000, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_JMP,  12'o0340, 12'o0,    0, 0, 1, mke(12'o0340, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_DISP, 12'o0340, 12'o0017, 0, 0, 1, mke(12'o0357, 5'd0, 0, 2'b00)));
        s.push_back(mk(3'd5,   12'o5555, 12'o0,    0, 0, 1, mke(12'o0360, 5'd0, 0, 2'b00)));
        s.push_back(mk(3'd7,   12'o5555, 12'o0,    0, 0, 1, mke(12'o0361, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_JMP,  12'o7777, 12'o0,    0, 0, 1, mke(12'o7777, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o0500, 12'o0,    0, 0, 1, mke(12'o0500, 5'd1, 0, 2'b00)));
        s.push_back(mk(S_RET,  12'o0,    12'o0,    0, 0, 1, mke(12'o0000, 5'd0, 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL wrap_jump_disp[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(S_CALL, 12'o0600, 12'o0, 0, 0, 1, mke(12'o0600, 5'd1, 0, 2'b00)));
        s.push_back(mk(S_RET,  12'o0,    12'o0, 0, 0, 1, mke(12'o0001, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o0700, 12'o0, 0, 0, 1, mke(12'o0700, 5'd1, 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o0710, 12'o0, 0, 0, 1, mke(12'o0710, 5'd2, 0, 2'b00)));
        s.push_back(mk(S_RET,  12'o0,    12'o0, 0, 0, 1, mke(12'o0701, 5'd1, 0, 2'b00)));
        s.push_back(mk(S_RET,  12'o0,    12'o0, 0, 0, 1, mke(12'o0002, 5'd0, 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    task automatic test_clken_hold();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(S_SEQ,  12'o0,    12'o0, 1, 0, 1, mke(12'o0000, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o0100, 12'o0, 0, 0, 1, mke(12'o0100, 5'd1, 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o0200, 12'o0, 0, 0, 1, mke(12'o0200, 5'd2, 0, 2'b00)));
        s.push_back(mk(S_CALL, 12'o0300, 12'o0, 0, 0, 1, mke(12'o0300, 5'd3, 0, 2'b00)));
        for (int i = 0; i < 5; i++)
            s.push_back(mk(S_CALL, 12'o7000, 12'o0, 0, 0, 0, mke(12'o0300, 5'd3, 0, 2'b00)));
        s.push_back(mk(S_SEQ,  12'o0,    12'o0, 1, 0, 0, mke(12'o0300, 5'd3, 0, 2'b00)));
        s.push_back(mk(S_RET,  12'o0,    12'o0, 0, 0, 0, mke(12'o0300, 5'd3, 0, 2'b00)));
        s.push_back(mk(S_RET,  12'o0,    12'o0, 0, 0, 1, mke(12'o0201, 5'd2, 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL clken_hold[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    task automatic test_async_reset();
        step_t s[$];
        exp_t  e;
        apply(mk(S_CALL, 12'o0400, 12'o0, 0, 0, 1, mke(12'o0400, 5'd3, 0, 2'b00)));
        tick();
        // Assert reset between edges and look before the next posedge.
        #2 rst_n = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(mke(12'o0000, 5'd0, 0, 2'b00));
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                     addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
        end
        #2 rst_n = 1'b1;
        s.push_back(mk(S_RET, 12'o0, 12'o0, 0, 0, 1, mke(12'o0000, 5'd0, 1, 2'b10)));
        s.push_back(mk(S_SEQ, 12'o0, 12'o0, 0, 1, 1, mke(12'o0000, 5'd0, 0, 2'b00)));
        s.push_back(mk(S_SEQ, 12'o0, 12'o0, 0, 0, 1, mke(12'o0001, 5'd0, 0, 2'b00)));
        foreach (s[i]) begin
            apply(s[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({addr, depth, fault, fault_code} !== {e.addr, e.depth, e.fault, e.code}) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got addr=%o depth=%0d fault=%b code=%b, expected addr=%o depth=%0d fault=%b code=%b",
                         i, addr, depth, fault, fault_code, e.addr, e.depth, e.fault, e.code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wrap_jump_disp();
        test_back_to_back();
        test_clken_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
